accum_mc: RTL and testbench
===========================

# accum_mc

Multi-channel, pipelined signed accumulator. It is the parametrised successor to the team's single-channel accumulator and adds:
- N independent channel accumulators sharing one adder;
- a per-sample channel select and a per-sample restart;
- a saturate-or-wrap mode with per-operation and sticky overflow/underflow flags;
- a registered 2-stage pipeline with same-channel forwarding.

It sits between a sample source and downstream consumers that need a running sum per stream.

## Interface
- NUM_CH, 4: number of channels; ≥1. CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1.
- DIN_WIDTH, 32: signed input sample width.
- DOUT_WIDTH, 40: signed accumulator width; must be ≥ DIN_WIDTH.
- SATURATE, 1: 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present this cycle.
- in_ch  in  CH_W  target channel.
- in_data  in  DIN_WIDTH  signed sample.
- in_restart  in  1  with in_valid: channel loads sext(in_data) instead of adding.
- clear_all  in  1  zero every channel and flag.
- out_valid  out  1  result for one accepted sample.
- out_ch  out  CH_W  channel of the result.
- out_accum  out  DOUT_WIDTH  new accumulator value of out_ch.
- out_ovf  out  1  this operation overflowed/underflowed.
- ovf_sticky  out  NUM_CH  per-channel sticky overflow flag.

## Operation
- State: acc[NUM_CH] of DOUT_WIDTH signed, and ovf_sticky[NUM_CH]. No backpressure; one sample accepted per cycle.
- Accept rule: a sample is accepted when in_valid=1, in_ch<NUM_CH, rst=0 and clear_all=0. A sample with in_ch≥NUM_CH is dropped silently: no output, no state change.
- Stage 1 (S1): registers ch, data, restart and valid. Reads acc[ch].
- Stage 2 (S2): computes the result, writes acc[ch] and ovf_sticky[ch], and drives the outputs.
- Arithmetic:
  - sext = DIN_WIDTH sign-extended to DOUT_WIDTH+1.
  - sum = {acc[msb],acc} + sext, computed at DOUT_WIDTH+1 bits.
  - ovf = sum[DOUT_WIDTH] != sum[DOUT_WIDTH-1].
- Result when ovf=0: sum[DOUT_WIDTH-1:0].
- Result when ovf=1 and SATURATE=1: the maximum positive value (0111…1) if sum[DOUT_WIDTH]=0, else the minimum negative value (1000…0).
- Result when ovf=1 and SATURATE=0: the wrapped low DOUT_WIDTH bits.
- out_ovf=ovf. ovf_sticky[ch] is set on ovf and is cleared only by restart, clear_all or rst.
- Restart: result = sext(in_data), out_ovf=0, ovf_sticky[ch] cleared. The old value is discarded.
- Forwarding: if S2 writes channel c in the same cycle S1 reads c, S1 uses the S2 result, not the stale acc[c]. Back-to-back same-channel samples therefore accumulate exactly.
- clear_all and rst both:
  - zero all acc and ovf_sticky;
  - kill the S1/S2 valids (in-flight samples produce no output);
  - ignore in_valid in that cycle.
- Simultaneous clear_all and rst: identical effect.

## Timing
- Latency 2: a sample accepted at edge N gives out_valid=1 and the outputs at edge N+2 (visible in cycle N+2).
- Throughput: 1 sample/cycle, any channel mix.
- All outputs are registered.
- Reset values: out_valid=0, out_ch=0, out_accum=0, out_ovf=0, ovf_sticky=0, all acc=0.
- While out_valid=0, out_ch, out_accum and out_ovf hold their last values. Benches must check them only when out_valid=1.
- clear_all asserted at edge N: ovf_sticky reads 0 from cycle N+1. No out_valid is produced at N+1 or N+2 for samples accepted at N-1 or N-2.
- A sample accepted at edge N+1 after clear_all sees acc=0.
- rst mid-stream: same as clear_all. The first accepted sample after rst deasserts gets out_valid two cycles later.

## Test plan
- Reset, then ch0 samples 5, -3, 10 on consecutive cycles → out_accum 5, 2, 12 at +2, +3, +4 cycles; out_ch=0; out_ovf=0.
- Interleave ch0 +1 and ch1 +100 alternately, 4 each → final ch0=4, ch1=400; no cross-talk; the back-to-back forwarding path is exercised.
- DIN_WIDTH=8, DOUT_WIDTH=8, SATURATE=1: ch2 receives 100 then 100 → outputs 100, then 127 with out_ovf=1 and ovf_sticky[2]=1. A further -1 gives 126 with out_ovf=0 and sticky still 1.
- Same widths with SATURATE=0: 100 + 100 → -56 with out_ovf=1. -128 + -1 → 127 with out_ovf=1.
- ch3 accumulated to 50, then a restart sample of 7 → out_accum=7, sticky[3]=0. The next sample of +1 gives 8.
- Three ch0 samples in flight, then clear_all for one cycle → no out_valid for the killed samples, all channels read 0. A sample of 9 the next cycle gives 9.
- With NUM_CH=3, a sample on in_ch=3 → no out_valid and no state change.

Source files
------------

// File: rtl/accum_mc.sv
// Multi-channel pipelined signed accumulator: one shared adder, per-channel state,
// S1 (capture + read) -> S2 (add/saturate/write) with same-channel forwarding.

module accum_mc_lane #(
  parameter int DOUT_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [DOUT_WIDTH-1:0] i_val,
  input  logic                  i_ovf,
  input  logic                  i_restart,
  output logic [DOUT_WIDTH-1:0] o_acc,
  output logic                  o_sticky
);
  logic [DOUT_WIDTH-1:0] r_acc;
  logic                  r_sticky;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_acc    <= '0;
      r_sticky <= 1'b0;
    end else if (i_we) begin
      r_acc <= i_val;
      if (i_restart)  r_sticky <= 1'b0;
      else if (i_ovf) r_sticky <= 1'b1;
    end
  end

  assign o_acc    = r_acc;
  assign o_sticky = r_sticky;
endmodule

module accum_mc #(
  parameter  int NUM_CH     = 4,
  parameter  int DIN_WIDTH  = 32,
  parameter  int DOUT_WIDTH = 40,
  parameter  int SATURATE   = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DIN_WIDTH-1:0]  in_data,
  input  logic                  in_restart,
  input  logic                  clear_all,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [DOUT_WIDTH-1:0] out_accum,
  output logic                  out_ovf,
  output logic [NUM_CH-1:0]     ovf_sticky
);
  localparam int              SW   = DOUT_WIDTH + 1;
  localparam logic [CH_W:0]   NCH  = (CH_W+1)'(NUM_CH);
  localparam logic [DOUT_WIDTH-1:0] MAXP = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] MINN = ~MAXP;

  logic w_clr, w_accept;
  assign w_clr    = rst | clear_all;
  assign w_accept = in_valid && ({1'b0, in_ch} < NCH) && !w_clr;

  // [0]=S1 holds a sample, [1]=S2 holds a sample, [2]=result registered
  logic [2:0] r_vld_pipe;

  logic [CH_W-1:0]       r_s1_ch, r_s2_ch, r_out_ch;
  logic [DIN_WIDTH-1:0]  r_s1_data, r_s2_data;
  logic                  r_s1_restart, r_s2_restart;
  logic [DOUT_WIDTH-1:0] r_s2_acc, r_out_accum;
  logic                  r_out_ovf;

  logic [NUM_CH-1:0][DOUT_WIDTH-1:0] w_acc;
  logic [NUM_CH-1:0]                 w_sticky;
  logic [DOUT_WIDTH-1:0]             w_s1_acc, w_res;
  logic [SW-1:0]                     w_sext, w_sum;
  logic                              w_sum_ovf, w_ovf;

  // S2 arithmetic at DOUT_WIDTH+1 bits so the top two bits reveal overflow
  assign w_sext    = {{(SW-DIN_WIDTH){r_s2_data[DIN_WIDTH-1]}}, r_s2_data};
  assign w_sum     = {r_s2_acc[DOUT_WIDTH-1], r_s2_acc} + w_sext;
  assign w_sum_ovf = w_sum[SW-1] ^ w_sum[SW-2];

  always_comb begin
    w_ovf = 1'b0;
    w_res = w_sum[DOUT_WIDTH-1:0];
    if (r_s2_restart) begin
      w_res = w_sext[DOUT_WIDTH-1:0];
    end else if (w_sum_ovf) begin
      w_ovf = 1'b1;
      if (SATURATE != 0) w_res = w_sum[SW-1] ? MINN : MAXP;
    end
  end

  // S1 read; S2 result bypasses the array when it targets the same channel
  always_comb begin
    w_s1_acc = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_s1_ch == CH_W'(i)) w_s1_acc = w_acc[i];
    if (r_vld_pipe[1] && (r_s2_ch == r_s1_ch)) w_s1_acc = w_res;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_ch      <= in_ch;
      r_s1_data    <= in_data;
      r_s1_restart <= in_restart;
    end
    if (r_vld_pipe[0]) begin
      r_s2_ch      <= r_s1_ch;
      r_s2_data    <= r_s1_data;
      r_s2_restart <= r_s1_restart;
      r_s2_acc     <= w_s1_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_out_ch    <= '0;
      r_out_accum <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_vld_pipe <= clear_all ? 3'b000 : {r_vld_pipe[1:0], w_accept};
      if (r_vld_pipe[1] && !clear_all) begin
        r_out_ch    <= r_s2_ch;
        r_out_accum <= w_res;
        r_out_ovf   <= w_ovf;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    accum_mc_lane #(.DOUT_WIDTH(DOUT_WIDTH)) u_lane (
      .clk       (clk),
      .i_clr     (w_clr),
      .i_we      (r_vld_pipe[1] && (r_s2_ch == CH_W'(g))),
      .i_val     (w_res),
      .i_ovf     (w_ovf),
      .i_restart (r_s2_restart),
      .o_acc     (w_acc[g]),
      .o_sticky  (w_sticky[g])
    );
  end

  assign out_valid  = r_vld_pipe[2];
  assign out_ch     = r_out_ch;
  assign out_accum  = r_out_accum;
  assign out_ovf    = r_out_ovf;
  assign ovf_sticky = w_sticky;
endmodule

// File: tb/tb_accum_mc.sv
// Directed bench for accum_mc: wide default instance, 8-bit saturate and wrap
// instances, and a 3-channel instance for out-of-range channel drops.

module tb_accum_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // A: 4 ch, 32 -> 40, saturate
  logic a_valid = 0, a_restart = 0, a_clear = 0;
  logic [1:0] a_ch = 0, a_och;
  logic [31:0] a_data = 0;
  logic a_ovalid, a_oovf;
  logic [39:0] a_oacc;
  logic [3:0] a_sticky;
  // S: 4 ch, 8 -> 8, saturate
  logic s_valid = 0, s_restart = 0, s_clear = 0;
  logic [1:0] s_ch = 0, s_och;
  logic [7:0] s_data = 0, s_oacc;
  logic s_ovalid, s_oovf;
  logic [3:0] s_sticky;
  // W: 4 ch, 8 -> 8, wrap
  logic w_valid = 0, w_restart = 0, w_clear = 0;
  logic [1:0] w_ch = 0, w_och;
  logic [7:0] w_data = 0, w_oacc;
  logic w_ovalid, w_oovf;
  logic [3:0] w_sticky;
  // T: 3 ch, 32 -> 40
  logic t_valid = 0, t_restart = 0, t_clear = 0;
  logic [1:0] t_ch = 0, t_och;
  logic [31:0] t_data = 0;
  logic t_ovalid, t_oovf;
  logic [39:0] t_oacc;
  logic [2:0] t_sticky;

  accum_mc #(.NUM_CH(4), .DIN_WIDTH(32), .DOUT_WIDTH(40), .SATURATE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ch(a_ch), .in_data(a_data),
    .in_restart(a_restart), .clear_all(a_clear), .out_valid(a_ovalid), .out_ch(a_och),
    .out_accum(a_oacc), .out_ovf(a_oovf), .ovf_sticky(a_sticky));
  accum_mc #(.NUM_CH(4), .DIN_WIDTH(8), .DOUT_WIDTH(8), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_ch(s_ch), .in_data(s_data),
    .in_restart(s_restart), .clear_all(s_clear), .out_valid(s_ovalid), .out_ch(s_och),
    .out_accum(s_oacc), .out_ovf(s_oovf), .ovf_sticky(s_sticky));
  accum_mc #(.NUM_CH(4), .DIN_WIDTH(8), .DOUT_WIDTH(8), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ch(w_ch), .in_data(w_data),
    .in_restart(w_restart), .clear_all(w_clear), .out_valid(w_ovalid), .out_ch(w_och),
    .out_accum(w_oacc), .out_ovf(w_oovf), .ovf_sticky(w_sticky));
  accum_mc #(.NUM_CH(3), .DIN_WIDTH(32), .DOUT_WIDTH(40), .SATURATE(1)) dut_t (
    .clk(clk), .rst(rst), .in_valid(t_valid), .in_ch(t_ch), .in_data(t_data),
    .in_restart(t_restart), .clear_all(t_clear), .out_valid(t_ovalid), .out_ch(t_och),
    .out_accum(t_oacc), .out_ovf(t_oovf), .ovf_sticky(t_sticky));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (a_ovalid !== 1'b0 || a_och !== 2'd0 || a_oacc !== 40'd0 || a_oovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_a_out: valid=%0b ch=%0d acc=%0d ovf=%0b, expected all 0",
               a_ovalid, a_och, a_oacc, a_oovf);
    end
    checks++;
    if (a_sticky !== 4'd0 || s_sticky !== 4'd0 || w_sticky !== 4'd0 || t_sticky !== 3'd0) begin
      failures++;
      $display("FAIL reset_sticky: a=%b s=%b w=%b t=%b, expected 0", a_sticky, s_sticky, w_sticky, t_sticky);
    end
    checks++;
    if (s_ovalid !== 1'b0 || w_ovalid !== 1'b0 || t_ovalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: s=%0b w=%0b t=%0b, expected 0", s_ovalid, w_ovalid, t_ovalid);
    end
  endtask

  task automatic test_basic();
    int d[3] = '{5, -3, 10};
    int e[3] = '{5, 2, 12};
    for (int k = 0; k < 6; k++) begin
      a_valid = (k < 3); a_ch = 0; a_restart = 0;
      a_data = (k < 3) ? 32'(d[k]) : 32'd0;
      tick();
      if (k >= 2 && k < 5) begin
        checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'd0 || a_oacc !== 40'(e[k-2]) || a_oovf !== 1'b0) begin
          failures++;
          $display("FAIL basic[%0d]: valid=%0b ch=%0d acc=%0d ovf=%0b, expected 1 0 %0d 0",
                   k-2, a_ovalid, a_och, $signed(a_oacc), a_oovf, e[k-2]);
        end
      end else if (k == 5) begin
        checks++;
        if (a_ovalid !== 1'b0) begin
          failures++;
          $display("FAIL basic_idle: valid=%0b, expected 0", a_ovalid);
        end
      end
    end
  endtask

  task automatic test_interleave();
    a_clear = 1; tick(); a_clear = 0;
    for (int k = 0; k < 10; k++) begin
      a_valid = (k < 8); a_ch = 2'(k % 2); a_restart = 0;
      a_data = (k % 2) ? 32'd100 : 32'd1;
      tick();
      if (k >= 2) begin
        int c = (k - 2) % 2;
        int x = c ? 100 * ((k - 2) / 2 + 1) : ((k - 2) / 2 + 1);
        checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'(c) || a_oacc !== 40'(x)) begin
          failures++;
          $display("FAIL interleave[%0d]: valid=%0b ch=%0d acc=%0d, expected 1 %0d %0d",
                   k-2, a_ovalid, a_och, $signed(a_oacc), c, x);
        end
      end
    end
    a_valid = 0;
  endtask

  task automatic test_back_to_back();
    int ch[4] = '{1, 1, 0, 1};
    int d[4]  = '{5, 5, 1, 5};
    int e[4]  = '{405, 410, 5, 415};
    for (int k = 0; k < 6; k++) begin
      a_valid = (k < 4); a_restart = 0;
      a_ch = (k < 4) ? 2'(ch[k]) : 2'd0;
      a_data = (k < 4) ? 32'(d[k]) : 32'd0;
      tick();
      if (k >= 2) begin
        checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'(ch[k-2]) || a_oacc !== 40'(e[k-2])) begin
          failures++;
          $display("FAIL back_to_back[%0d]: valid=%0b ch=%0d acc=%0d, expected 1 %0d %0d",
                   k-2, a_ovalid, a_och, $signed(a_oacc), ch[k-2], e[k-2]);
        end
      end
    end
    a_valid = 0;
  endtask

  task automatic test_saturate();
    int ch[5] = '{2, 2, 2, 1, 1};
    int d[5]  = '{100, 100, -1, -128, -1};
    int e[5]  = '{100, 127, 126, -128, -128};
    int o[5]  = '{0, 1, 0, 0, 1};
    for (int k = 0; k < 7; k++) begin
      s_valid = (k < 5); s_restart = 0;
      s_ch = (k < 5) ? 2'(ch[k]) : 2'd0;
      s_data = (k < 5) ? 8'(d[k]) : 8'd0;
      tick();
      if (k >= 2) begin
        checks++;
        if (s_ovalid !== 1'b1 || s_och !== 2'(ch[k-2]) || s_oacc !== 8'(e[k-2]) || s_oovf !== 1'(o[k-2])) begin
          failures++;
          $display("FAIL saturate[%0d]: valid=%0b ch=%0d acc=%0d ovf=%0b, expected 1 %0d %0d %0d",
                   k-2, s_ovalid, s_och, $signed(s_oacc), s_oovf, ch[k-2], e[k-2], o[k-2]);
        end
      end
    end
    s_valid = 0;
    checks++;
    if (s_sticky !== 4'b0110) begin
      failures++;
      $display("FAIL saturate_sticky: got %b, expected 0110", s_sticky);
    end
  endtask

  task automatic test_wrap();
    int ch[4] = '{0, 0, 1, 1};
    int d[4]  = '{100, 100, -128, -1};
    int e[4]  = '{100, -56, -128, 127};
    int o[4]  = '{0, 1, 0, 1};
    for (int k = 0; k < 6; k++) begin
      w_valid = (k < 4); w_restart = 0;
      w_ch = (k < 4) ? 2'(ch[k]) : 2'd0;
      w_data = (k < 4) ? 8'(d[k]) : 8'd0;
      tick();
      if (k >= 2) begin
        checks++;
        if (w_ovalid !== 1'b1 || w_och !== 2'(ch[k-2]) || w_oacc !== 8'(e[k-2]) || w_oovf !== 1'(o[k-2])) begin
          failures++;
          $display("FAIL wrap[%0d]: valid=%0b ch=%0d acc=%0d ovf=%0b, expected 1 %0d %0d %0d",
                   k-2, w_ovalid, w_och, $signed(w_oacc), w_oovf, ch[k-2], e[k-2], o[k-2]);
        end
      end
    end
    w_valid = 0;
    checks++;
    if (w_sticky !== 4'b0011) begin
      failures++;
      $display("FAIL wrap_sticky: got %b, expected 0011", w_sticky);
    end
  endtask

  task automatic test_restart();
    int d[5]  = '{100, 100, -77, 7, 1};
    int r[5]  = '{0, 0, 0, 1, 0};
    int e[5]  = '{100, 127, 50, 7, 8};
    int o[5]  = '{0, 1, 0, 0, 0};
    int st[5] = '{0, 1, 1, 0, 0};
    for (int k = 0; k < 7; k++) begin
      s_valid = (k < 5); s_ch = 2'd3;
      s_restart = (k < 5) ? 1'(r[k]) : 1'b0;
      s_data = (k < 5) ? 8'(d[k]) : 8'd0;
      tick();
      if (k >= 2) begin
        checks++;
        if (s_ovalid !== 1'b1 || s_och !== 2'd3 || s_oacc !== 8'(e[k-2]) ||
            s_oovf !== 1'(o[k-2]) || s_sticky[3] !== 1'(st[k-2])) begin
          failures++;
          $display("FAIL restart[%0d]: valid=%0b ch=%0d acc=%0d ovf=%0b sticky3=%0b, expected 1 3 %0d %0d %0d",
                   k-2, s_ovalid, s_och, $signed(s_oacc), s_oovf, s_sticky[3], e[k-2], o[k-2], st[k-2]);
        end
      end
    end
    s_valid = 0; s_restart = 0;
  endtask

  task automatic test_clear();
    // inputs per step: channel, data, clear; ch0 starts at 5, ch1 at 415
    int ch[7] = '{0, 0, 0, 0, 1, 2, 3};
    int d[7]  = '{1, 2, 3, 9, 0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      a_valid = (k < 7); a_restart = 0;
      a_ch = (k < 7) ? 2'(ch[k]) : 2'd0;
      a_data = (k < 7) ? 32'(d[k]) : 32'd0;
      a_clear = (k == 2);
      s_clear = (k == 2);
      tick();
      if (k < 5) begin
        checks++;
        if (a_ovalid !== 1'b0) begin
          failures++;
          $display("FAIL clear_killed[%0d]: valid=%0b, expected 0", k, a_ovalid);
        end
      end else begin
        int c = k - 5;
        int x = (k == 5) ? 9 : 0;
        checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'(c) || a_oacc !== 40'(x)) begin
          failures++;
          $display("FAIL clear_after[%0d]: valid=%0b ch=%0d acc=%0d, expected 1 %0d %0d",
                   k, a_ovalid, a_och, $signed(a_oacc), c, x);
        end
      end
      if (k == 2) begin
        checks++;
        if (s_sticky !== 4'd0) begin
          failures++;
          $display("FAIL clear_sticky: got %b, expected 0000", s_sticky);
        end
      end
    end
    a_valid = 0; a_clear = 0; s_clear = 0;
  endtask

  task automatic test_rst_midstream();
    int d[4] = '{7, 7, 7, 3};
    for (int k = 0; k < 6; k++) begin
      a_valid = (k < 4); a_ch = 2'd1; a_restart = 0;
      a_data = (k < 4) ? 32'(d[k]) : 32'd0;
      rst = (k == 2);
      tick();
      if (k == 2) begin
        checks++;
        if (a_ovalid !== 1'b0 || a_oacc !== 40'd0 || a_och !== 2'd0) begin
          failures++;
          $display("FAIL rst_mid: valid=%0b ch=%0d acc=%0d, expected 0 0 0", a_ovalid, a_och, $signed(a_oacc));
        end
      end else if (k > 2 && k < 5) begin
        checks++;
        if (a_ovalid !== 1'b0) begin
          failures++;
          $display("FAIL rst_killed[%0d]: valid=%0b, expected 0", k, a_ovalid);
        end
      end else if (k == 5) begin
        checks++;
        if (a_ovalid !== 1'b1 || a_och !== 2'd1 || a_oacc !== 40'd3) begin
          failures++;
          $display("FAIL rst_after: valid=%0b ch=%0d acc=%0d, expected 1 1 3", a_ovalid, a_och, $signed(a_oacc));
        end
      end
    end
    a_valid = 0; rst = 0;
  endtask

  task automatic test_drop();
    int ch[4] = '{0, 3, 0, 2};
    int d[4]  = '{10, 55, 1, 0};
    for (int k = 0; k < 6; k++) begin
      t_valid = (k < 4); t_restart = 0;
      t_ch = (k < 4) ? 2'(ch[k]) : 2'd0;
      t_data = (k < 4) ? 32'(d[k]) : 32'd0;
      tick();
      if (k == 3) begin
        checks++;
        if (t_ovalid !== 1'b0) begin
          failures++;
          $display("FAIL drop_novalid: valid=%0b, expected 0", t_ovalid);
        end
      end else if (k >= 2) begin
        int c = ch[k-2];
        int x = (k == 2) ? 10 : ((k == 4) ? 11 : 0);
        checks++;
        if (t_ovalid !== 1'b1 || t_och !== 2'(c) || t_oacc !== 40'(x)) begin
          failures++;
          $display("FAIL drop[%0d]: valid=%0b ch=%0d acc=%0d, expected 1 %0d %0d",
                   k, t_ovalid, t_och, $signed(t_oacc), c, x);
        end
      end
    end
    t_valid = 0;
    checks++;
    if (t_sticky !== 3'd0) begin
      failures++;
      $display("FAIL drop_sticky: got %b, expected 000", t_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_back_to_back();
    test_saturate();
    test_wrap();
    test_restart();
    test_clear();
    test_rst_midstream();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
